// File: rtl/audio_pkg.sv
// Shared audio-path constants, DAC frame helpers and the serializer state type.
// The volume helper is used only when AUDIO_DAC_VOLUME_EN is defined.
package audio_pkg;

  localparam int               AUDIO_W       = 12;
  localparam int               DAC_FRAME_W   = 16;
  localparam logic [3:0]       DAC_CTRL_BITS = 4'b0000;
  localparam logic [AUDIO_W-1:0] MIDSCALE    = 12'h800;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } dac_state_t;

  function automatic logic [DAC_FRAME_W-1:0] dac_frame(input logic [AUDIO_W-1:0] s);
    return {DAC_CTRL_BITS, s};
  endfunction

  // Attenuate around midscale: signed 13-bit offset, arithmetic shift, wrap to 12 bits.
  function automatic logic [AUDIO_W-1:0] scale_sample(input logic [AUDIO_W-1:0] s,
                                                       input logic [2:0] vol);
    logic signed [AUDIO_W:0] d;
    d = $signed({1'b0, s}) - $signed({1'b0, MIDSCALE});
    d = d >>> vol;
    return AUDIO_W'({1'b0, MIDSCALE} + d);
  endfunction

endpackage

// File: rtl/audio_sample_tick.sv
// Free-running sample-rate divider: tick is high for one cycle every DIV cycles.
module audio_sample_tick #(
  parameter int DIV = 5000
) (
  input  logic clk100M,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk100M) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/audio_dac_serializer.sv
// Streams one 12-bit sample per tick to a DAC121S101-style serial DAC as a 16-bit frame.
// Optional feature macro: AUDIO_DAC_VOLUME_EN adds the volume port (right-shift attenuation).
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SCLK_HALF  = 4,
  parameter int SAMPLE_DIV = 5000
) (
  input  logic               clk100M,
  input  logic               reset,
`ifdef AUDIO_DAC_VOLUME_EN
  input  logic [2:0]         volume,
`endif
  input  logic [AUDIO_W-1:0] sample_in,
  output logic               dac_sclk,
  output logic               dac_sync_n,
  output logic               dac_din,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam int HW = $clog2(SCLK_HALF);

  logic tick;

  audio_sample_tick #(
    .DIV(SAMPLE_DIV)
  ) u_tick (
    .clk100M(clk100M),
    .reset  (reset),
    .tick   (tick)
  );

  logic [AUDIO_W-1:0]     load_sample;
  logic [DAC_FRAME_W-1:0] frame_word;

`ifdef AUDIO_DAC_VOLUME_EN
  assign load_sample = scale_sample(sample_in, volume);
`else
  assign load_sample = sample_in;
`endif
  assign frame_word = dac_frame(load_sample);

  dac_state_t             state_q, state_d;
  logic [HW-1:0]          half_q, half_d;
  logic [3:0]             bit_q, bit_d;
  logic [DAC_FRAME_W-1:0] sr_q, sr_d;
  logic                   sclk_q, sclk_d;
  logic                   sync_n_q, sync_n_d;
  logic                   din_q, din_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    din_d    = din_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q | (tick && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        half_d = '0;
        bit_d  = '0;
        if (tick) begin
          din_d    = frame_word[DAC_FRAME_W-1];
          sr_d     = {frame_word[DAC_FRAME_W-2:0], 1'b0};
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (half_q == HW'(SCLK_HALF - 1)) begin
          half_d = '0;
          sclk_d = ~sclk_q;
          // Rising toggle: either present the next bit or close the frame after bit 0.
          if (!sclk_q) begin
            if (bit_q == 4'd15) begin
              state_d  = GAP;
              sync_n_d = 1'b1;
              done_d   = 1'b1;
              din_d    = 1'b0;
            end else begin
              din_d = sr_q[DAC_FRAME_W-1];
              sr_d  = {sr_q[DAC_FRAME_W-2:0], 1'b0};
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      GAP: begin
        if (half_q == HW'(SCLK_HALF - 1)) begin
          half_d  = '0;
          state_d = IDLE;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk100M) begin
    if (reset) begin
      state_q  <= IDLE;
      half_q   <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_din    = din_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: two instances (normal rate and overrunning rate) checked
// every cycle against a timing model derived from tick times and frame arithmetic.
module tb_audio_dac_serializer;

  localparam int H    = 2;
  localparam int DIV0 = 80;
  localparam int DIV1 = 40;

  logic        clk100M = 1'b0;
  logic        reset   = 1'b1;
  logic [11:0] sample_in = 12'h000;
`ifdef AUDIO_DAC_VOLUME_EN
  logic [2:0]  volume = 3'd0;
`endif

  logic sclk0, sync0, din0, busy0, fd0, ovr0;
  logic sclk1, sync1, din1, busy1, fd1, ovr1;

  always #5 clk100M = ~clk100M;

  audio_dac_serializer #(.SCLK_HALF(H), .SAMPLE_DIV(DIV0)) dut0 (
    .clk100M   (clk100M),
    .reset     (reset),
`ifdef AUDIO_DAC_VOLUME_EN
    .volume    (volume),
`endif
    .sample_in (sample_in),
    .dac_sclk  (sclk0),
    .dac_sync_n(sync0),
    .dac_din   (din0),
    .busy      (busy0),
    .frame_done(fd0),
    .overrun   (ovr0)
  );

  audio_dac_serializer #(.SCLK_HALF(H), .SAMPLE_DIV(DIV1)) dut1 (
    .clk100M   (clk100M),
    .reset     (reset),
`ifdef AUDIO_DAC_VOLUME_EN
    .volume    (volume),
`endif
    .sample_in (sample_in),
    .dac_sclk  (sclk1),
    .dac_sync_n(sync1),
    .dac_din   (din1),
    .busy      (busy1),
    .frame_done(fd1),
    .overrun   (ovr1)
  );

  logic sclk_a[2], sync_a[2], din_a[2], busy_a[2], fd_a[2], ovr_a[2];
  assign sclk_a[0] = sclk0;  assign sclk_a[1] = sclk1;
  assign sync_a[0] = sync0;  assign sync_a[1] = sync1;
  assign din_a[0]  = din0;   assign din_a[1]  = din1;
  assign busy_a[0] = busy0;  assign busy_a[1] = busy1;
  assign fd_a[0]   = fd0;    assign fd_a[1]   = fd1;
  assign ovr_a[0]  = ovr0;   assign ovr_a[1]  = ovr1;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d cycle=%0d observed=0x%0h expected=0x%0h",
                tag, inst, cyc, obs, exp);
  endtask

  function automatic logic [11:0] exp_load(input logic [11:0] s);
`ifdef AUDIO_DAC_VOLUME_EN
    int d;
    d = int'(s) - 2048;
    d = d >>> volume;
    return 12'((d + 2048) & 32'hFFF);
`else
    return s;
`endif
  endfunction

  // Model state: tick counter position, accepted frame start/end and expected word.
  int          k_m[2]   = '{0, 0};
  int          s_m[2]   = '{-1000, -1000};
  int          end_m[2] = '{-1000, -1000};
  logic [15:0] word_m[2];
  logic        ovr_m[2] = '{1'b0, 1'b0};
  // DAC-side capture: bits taken on falling sclk while sync_n is low.
  logic [15:0] cap_w[2];
  int          cap_n[2]  = '{0, 0};
  int          low_n[2]  = '{0, 0};
  logic        prev_sync[2] = '{1'b1, 1'b1};
  logic        prev_sclk[2] = '{1'b1, 1'b1};
  logic [15:0] last_word[2] = '{16'h0, 16'h0};

  always @(negedge clk100M) begin
    for (int i = 0; i < 2; i++) begin
      int   p;
      int   div;
      logic be;
      div = (i == 0) ? DIV0 : DIV1;

      if (!sync_a[i] && prev_sync[i]) begin
        cap_w[i] = 16'h0;
        cap_n[i] = 0;
        low_n[i] = 0;
      end
      if (!sync_a[i]) begin
        low_n[i]++;
        if (prev_sclk[i] && !sclk_a[i]) begin
          cap_w[i] = {cap_w[i][14:0], din_a[i]};
          cap_n[i]++;
        end
      end
      prev_sync[i] = sync_a[i];
      prev_sclk[i] = sclk_a[i];

      be = (cyc >= s_m[i] + 1) && (cyc < end_m[i]);
      p  = cyc - (s_m[i] + 1);
      check("busy", i, busy_a[i], be);
      check("overrun", i, ovr_a[i], ovr_m[i]);
      if (be && p < 32 * H) begin
        check("sync_n", i, sync_a[i], 1'b0);
        check("sclk", i, sclk_a[i], ((p / H) % 2) == 0);
        check("din", i, din_a[i], word_m[i][15 - p / (2 * H)]);
        check("frame_done", i, fd_a[i], 1'b0);
      end else begin
        check("sync_n", i, sync_a[i], 1'b1);
        check("sclk", i, sclk_a[i], 1'b1);
        check("frame_done", i, fd_a[i], be && (p == 32 * H));
      end
      if (be && p == 32 * H) begin
        check("frame_bits", i, cap_w[i], word_m[i]);
        check("frame_nbits", i, cap_n[i], 16);
        check("sync_low_cycles", i, low_n[i], 32 * H);
        last_word[i] = cap_w[i];
      end

      if (reset) begin
        k_m[i]   = 0;
        ovr_m[i] = 1'b0;
        if (be) end_m[i] = cyc + 1;
      end else begin
        if (k_m[i] == div - 1) begin
          if (be) begin
            ovr_m[i] = 1'b1;
          end else begin
            s_m[i]    = cyc;
            end_m[i]  = cyc + 1 + 33 * H;
            word_m[i] = {4'b0000, exp_load(sample_in)};
          end
        end
        k_m[i] = (k_m[i] + 1) % div;
      end
    end
    cyc++;
  end

  task automatic wait_busy(input logic lvl, input int maxc);
    int n = 0;
    while (busy0 !== lvl && n < maxc) begin
      @(posedge clk100M); #1;
      n++;
    end
    check("wait_busy", 0, busy0, lvl);
  endtask

  initial begin
    logic [11:0] smp;
`ifdef AUDIO_DAC_VOLUME_EN
    logic [11:0] vin[3]  = '{12'hFFF, 12'h000, 12'h800};
    logic [11:0] vout[3] = '{12'hBFF, 12'h400, 12'h800};
`endif
    reset = 1'b1;
    repeat (5) @(posedge clk100M);
    #1;
    check("rst_sclk", 0, sclk0, 1'b1);
    check("rst_sync_n", 0, sync0, 1'b1);
    check("rst_din", 0, din0, 1'b0);
    check("rst_busy", 0, busy0, 1'b0);
    check("rst_overrun", 0, ovr0, 1'b0);
    check("rst_frame_done", 0, fd0, 1'b0);
    check("rst_din", 1, din1, 1'b0);
    check("rst_busy", 1, busy1, 1'b0);
    repeat (195) @(posedge clk100M);
    #1;

    sample_in = 12'hA5C;
    reset = 1'b0;
    wait_busy(1'b1, 200);
    wait_busy(1'b0, 200);
    check("single_frame_word", 0, last_word[0], 16'h0A5C);

    sample_in = 12'h123;
    wait_busy(1'b1, 200);
    repeat (10) @(posedge clk100M);
    #1;
    sample_in = 12'hFFF;
    wait_busy(1'b0, 200);
    check("midchange_first", 0, last_word[0], 16'h0123);
    wait_busy(1'b1, 200);
    wait_busy(1'b0, 200);
    check("midchange_second", 0, last_word[0], 16'h0FFF);
    check("no_overrun", 0, ovr0, 1'b0);
    check("overrun_set", 1, ovr1, 1'b1);

    wait_busy(1'b1, 200);
    repeat (29) @(posedge clk100M);
    #1;
    reset = 1'b1;
    @(posedge clk100M);
    #1;
    reset = 1'b0;
    check("abort_sync_n", 0, sync0, 1'b1);
    check("abort_sclk", 0, sclk0, 1'b1);
    check("abort_busy", 0, busy0, 1'b0);
    check("abort_overrun", 1, ovr1, 1'b0);
    smp = 12'($urandom);
    sample_in = smp;
    wait_busy(1'b1, 200);
    wait_busy(1'b0, 200);
    check("post_abort_frame", 0, last_word[0], {4'h0, exp_load(smp)});

`ifdef AUDIO_DAC_VOLUME_EN
    volume = 3'd1;
    for (int v = 0; v < 3; v++) begin
      sample_in = vin[v];
      wait_busy(1'b1, 200);
      wait_busy(1'b0, 200);
      check("volume_frame", 0, last_word[0], {4'h0, vout[v]});
    end
`endif

    repeat (1500) begin
      @(posedge clk100M);
      #1;
      sample_in = 12'($urandom);
`ifdef AUDIO_DAC_VOLUME_EN
      volume = 3'($urandom);
`endif
      reset = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk100M);
    #1;
    reset = 1'b0;
    repeat (200) @(posedge clk100M);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Downstream stage of the audio path: takes the 12-bit `audio_out` sample from the audio mux and streams it to a DAC121S101-style serial DAC (Pmod DA2) at a fixed sample rate. The block generates its own sample tick. On each tick it latches one sample and shifts out a 16-bit frame on SCLK/SYNC/DIN. It reports busy, frame-done and a sticky overrun flag.

## Interface
Parameters:
- `SCLK_HALF`, default 4: clk100M cycles per SCLK half-period. Default gives 12.5 MHz SCLK. Must be ≥ 2.
- `SAMPLE_DIV`, default 5000: clk100M cycles per sample tick. Default gives 20 kHz. Must be > 33·SCLK_HALF + 1.

Ports:
- `clk100M` input, 1 bit: system clock, 100 MHz.
- `reset` input, 1 bit: synchronous, active-high.
- `sample_in` input, 12 bits: offset-binary audio sample, midscale 12'h800.
- `volume` input, 3 bits: right-shift attenuation. Present only with AUDIO_DAC_VOLUME_EN.
- `dac_sclk` output, 1 bit: serial clock. Idles high.
- `dac_sync_n` output, 1 bit: frame sync, active-low.
- `dac_din` output, 1 bit: serial data, MSB first.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `frame_done` output, 1 bit: one-cycle pulse at the end of each frame.
- `overrun` output, 1 bit: sticky. Set when a tick arrives while busy. Cleared only by reset.

## Operation
- Tick counter counts 0 … SAMPLE_DIV-1 and wraps. `tick` is asserted when count == SAMPLE_DIV-1. The counter free-runs and ignores state.
- Frame format is 16 bits: {2'b00 don't-care, 2'b00 power-down = normal, sample[11:0]}. Bits are sent bit15 first.
- FSM states are IDLE, SHIFT and GAP.
  - **IDLE**: on tick, load shift register with the frame word and go to SHIFT.
  - **SHIFT**: half-period counter runs 0 … SCLK_HALF-1. At wrap, toggle sclk.
    - On each rising toggle, shift the next bit onto din.
    - After the 16th falling edge plus one half-period, sclk rises. At that edge go to GAP, drive sync_n = 1 and pulse frame_done.
  - **GAP**: hold sync_n and sclk high for SCLK_HALF cycles, then go to IDLE.
- `sample_in` is sampled only on the tick cycle. Changes mid-frame do not affect the frame in flight.
- A tick in SHIFT or GAP is dropped and sets overrun. No queuing.
- DIN changes only while sclk is high or rising, so the DAC samples on falling edges with SCLK_HALF cycles of setup.

## Timing
- Reset values: dac_sclk = 1, dac_sync_n = 1, dac_din = 0, busy = 0, frame_done = 0, overrun = 0. Tick counter, half counter and bit counter are all 0. State is IDLE.
- All outputs are registered; there are no combinational paths from inputs.
- Let H = SCLK_HALF and tick be asserted at cycle T.
  - T+1: sync_n = 0, sclk = 1, din = bit15, busy = 1.
  - Bit k is driven from T+1+2kH to T+(2k+2)H.
  - The falling edge for bit k is at T+1+(2k+1)H.
  - T+1+32H: sync_n = 1, sclk = 1, frame_done = 1 for one cycle.
  - T+1+33H: busy = 0 (back in IDLE).
- sync_n is low for exactly 32H cycles per frame.
- Reset mid-frame takes effect at the next edge and forces the idle values. The DAC discards the partial frame because SYNC rises before the 16th falling edge.
- Reset and tick in the same cycle: reset wins and no frame starts.

## Configuration
- Macro: `AUDIO_DAC_VOLUME_EN`.
- **Defined**:
  - The `volume` port exists.
  - The loaded sample is MIDSCALE + ((sample_in − MIDSCALE) >>> volume). The subtraction is 13-bit signed and the result is truncated to 12 bits.
  - The scaling is computed combinationally into the tick-cycle latch, so latency is unchanged.
- **Undefined**: no `volume` port; sample_in is loaded unmodified.

## Structure
- Package `audio_pkg` holds:
  - `AUDIO_W = 12`
  - `DAC_FRAME_W = 16`
  - `DAC_CTRL_BITS = 4'b0000`
  - `MIDSCALE = 12'h800`
  - `dac_state_t` enum {IDLE, SHIFT, GAP}
- Sub-module `audio_sample_tick` (parameter DIV, ports clk100M, reset, tick). It is reusable by the other audio stages.

## Test plan
Bench parameters are SCLK_HALF = 2 and SAMPLE_DIV = 80 unless noted.
- **Reset**: hold reset 5 cycles → sclk = 1, sync_n = 1, din = 0, busy = 0, overrun = 0. No sync_n low for 200 cycles after reset while reset is held.
- **Single frame**: sample_in = 12'hA5C → bits captured on sclk falling edges are 0000_1010_0101_1100. sync_n is low for exactly 64 cycles. frame_done pulses once, 65 cycles after the tick.
- **Mid-frame change**: 12'h123 at tick, then 12'hFFF 10 cycles later → current frame carries 0x123 and the next frame carries 0xFFF. overrun = 0.
- **Overrun** (SAMPLE_DIV = 40) → the tick at 40 is dropped and overrun = 1. Frames start only at ticks 0, 80, 160, …
- **Reset mid-frame** at bit 7 → next cycle sync_n = 1, sclk = 1, busy = 0. A clean frame follows on the next tick.
- **Volume** (AUDIO_DAC_VOLUME_EN, volume = 1): 12'hFFF → 12'hBFF, 12'h000 → 12'h400, 12'h800 → 12'h800.
